// File: rtl/video_sync_gen_if.sv
// Raster timing bundle between the sync generator (master) and its consumers (slave).
// CSYNC exists only when VSG_CSYNC_EN is defined.
interface video_sync_gen_if;
  logic       SC_1H;
  logic [8:0] hcount;
  logic [8:0] vcount;
  logic       HBLANK;
  logic       VBLANK;
  logic       HSYNC;
  logic       VSYNC;
  logic       pix_tick;
  logic       line_start;
  logic       frame_start;
`ifdef VSG_CSYNC_EN
  logic       CSYNC;
`endif

  modport master (
    input  SC_1H,
    output hcount, vcount, HBLANK, VBLANK, HSYNC, VSYNC,
           pix_tick, line_start, frame_start
`ifdef VSG_CSYNC_EN
    , output CSYNC
`endif
  );

  modport slave (
    output SC_1H,
    input  hcount, vcount, HBLANK, VBLANK, HSYNC, VSYNC,
           pix_tick, line_start, frame_start
`ifdef VSG_CSYNC_EN
    , input CSYNC
`endif
  );
endinterface

// File: rtl/video_sync_gen.sv
// Raster timing generator: counts SC_1H rising edges into pixel/line positions and decodes
// blanking, sync and strobe outputs. Optional composite sync output with VSG_CSYNC_EN.
module video_sync_gen #(
  parameter int H_TOTAL      = 456,
  parameter int H_ACTIVE     = 320,
  parameter int H_SYNC_START = 336,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_TOTAL      = 262,
  parameter int V_ACTIVE     = 240,
  parameter int V_SYNC_START = 244,
  parameter int V_SYNC_LEN   = 3
) (
  input  logic             clk100,
  input  logic             rst,
  video_sync_gen_if.master vid
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
  localparam logic [8:0] H_SS   = 9'(H_SYNC_START);
  localparam logic [8:0] H_SE   = 9'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
  localparam logic [8:0] V_SS   = 9'(V_SYNC_START);
  localparam logic [8:0] V_SE   = 9'(V_SYNC_START + V_SYNC_LEN);

  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_t;

  // Later boundaries win so zero-length phases are skipped in a single step.
  function automatic phase_t phase_at(input phase_t cur, input logic [8:0] pos,
                                      input logic [8:0] act, input logic [8:0] ss,
                                      input logic [8:0] se);
    phase_t ph;
    ph = cur;
    if (pos == 9'd0)     ph = PH_ACT;
    else if (pos == se)  ph = PH_BP;
    else if (pos == ss)  ph = PH_SYNC;
    else if (pos == act) ph = PH_FP;
    return ph;
  endfunction

  logic       sc1h_q;
  logic       tick;
  logic       h_wrap;
  logic       v_wrap;
  logic [8:0] hcount_q, hcount_nxt;
  logic [8:0] vcount_q, vcount_nxt;
  phase_t     h_state, h_state_nxt;
  phase_t     v_state, v_state_nxt;

  logic       hblank_d, vblank_d, hsync_d, vsync_d, line_d, frame_d;
  logic       hblank_q, vblank_q, hsync_q, vsync_q, line_q, frame_q, pix_tick_q;

  // Stage 0: edge detect and next-state counters/phases.
  always_comb begin
    tick        = vid.SC_1H & ~sc1h_q;
    h_wrap      = (hcount_q == H_LAST);
    v_wrap      = (vcount_q == V_LAST);
    hcount_nxt  = hcount_q;
    vcount_nxt  = vcount_q;
    h_state_nxt = h_state;
    v_state_nxt = v_state;
    if (tick) begin
      hcount_nxt  = h_wrap ? 9'd0 : hcount_q + 9'd1;
      h_state_nxt = phase_at(h_state, hcount_nxt, H_ACT, H_SS, H_SE);
      if (h_wrap) begin
        vcount_nxt  = v_wrap ? 9'd0 : vcount_q + 9'd1;
        v_state_nxt = phase_at(v_state, vcount_nxt, V_ACT, V_SS, V_SE);
      end
    end
  end

  always_comb begin
    hblank_d = (h_state_nxt != PH_ACT);
    hsync_d  = (h_state_nxt == PH_SYNC);
    vblank_d = (v_state_nxt != PH_ACT);
    vsync_d  = (v_state_nxt == PH_SYNC);
    line_d   = tick & h_wrap;
    frame_d  = tick & h_wrap & v_wrap;
  end

  // Stage 1: counters, phases and decoded flags all land on the same edge.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      sc1h_q   <= 1'b1;
      hcount_q <= 9'd0;
      vcount_q <= 9'd0;
      h_state  <= PH_ACT;
      v_state  <= PH_ACT;
    end else begin
      sc1h_q   <= vid.SC_1H;
      hcount_q <= hcount_nxt;
      vcount_q <= vcount_nxt;
      h_state  <= h_state_nxt;
      v_state  <= v_state_nxt;
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      hblank_q   <= 1'b0;
      vblank_q   <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      line_q     <= 1'b0;
      frame_q    <= 1'b0;
      pix_tick_q <= 1'b0;
    end else begin
      hblank_q   <= hblank_d;
      vblank_q   <= vblank_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      line_q     <= line_d;
      frame_q    <= frame_d;
      pix_tick_q <= tick;
    end
  end

  assign vid.hcount      = hcount_q;
  assign vid.vcount      = vcount_q;
  assign vid.HBLANK      = hblank_q;
  assign vid.VBLANK      = vblank_q;
  assign vid.HSYNC       = hsync_q;
  assign vid.VSYNC       = vsync_q;
  assign vid.pix_tick    = pix_tick_q;
  assign vid.line_start  = line_q;
  assign vid.frame_start = frame_q;

`ifdef VSG_CSYNC_EN
  logic csync_q;

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) csync_q <= 1'b0;
    else     csync_q <= hsync_d ^ vsync_d;
  end

  assign vid.CSYNC = csync_q;
`endif

endmodule

// File: tb/tb_video_sync_gen.sv
// Directed bench for video_sync_gen: default raster for horizontal/reset behaviour and a
// small-raster instance for full-frame vertical timing.
module tb_video_sync_gen;
  logic clk100 = 1'b0;
  logic rst    = 1'b1;
  logic sc1h   = 1'b1;
  int   errors = 0;
  int   checks = 0;

  video_sync_gen_if vif_d();
  video_sync_gen_if vif_s();
  assign vif_d.SC_1H = sc1h;
  assign vif_s.SC_1H = sc1h;

  video_sync_gen dut_d (.clk100(clk100), .rst(rst), .vid(vif_d));

  // Small raster: FP of zero width horizontally, BP of zero width vertically.
  video_sync_gen #(
    .H_TOTAL(8), .H_ACTIVE(5), .H_SYNC_START(5), .H_SYNC_LEN(2),
    .V_TOTAL(10), .V_ACTIVE(6), .V_SYNC_START(7), .V_SYNC_LEN(3)
  ) dut_s (.clk100(clk100), .rst(rst), .vid(vif_s));

  always #5 clk100 = ~clk100;

  task automatic pix(input int per);
    sc1h = 1'b1;
    @(negedge clk100);
    repeat (per / 2 - 1) @(negedge clk100);
    sc1h = 1'b0;
    repeat (per - per / 2) @(negedge clk100);
  endtask

  function automatic logic [19:0] outs_d();
    return {vif_d.hcount, vif_d.vcount, vif_d.HBLANK, vif_d.VBLANK, vif_d.HSYNC,
            vif_d.VSYNC, vif_d.pix_tick, vif_d.line_start, vif_d.frame_start, 1'b0};
  endfunction

  task automatic test_reset();
    rst = 1'b1; sc1h = 1'b1;
    repeat (3) @(negedge clk100);
    checks++; if (outs_d() !== 20'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs_d()); end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk100);
      checks++; if (vif_d.pix_tick !== 1'b0) begin errors++; $display("FAIL hold_high_tick cyc %0d: got %b expected 0", i, vif_d.pix_tick); end
    end
    checks++; if (vif_d.hcount !== 9'd0) begin errors++; $display("FAIL hold_high_hcount: got %0d expected 0", vif_d.hcount); end
  endtask

  task automatic test_first_tick();
    sc1h = 1'b0; @(negedge clk100);
    sc1h = 1'b1; @(negedge clk100);
    checks++; if (vif_d.pix_tick !== 1'b1) begin errors++; $display("FAIL first_tick_pulse: got %b expected 1", vif_d.pix_tick); end
    checks++; if (vif_d.hcount !== 9'd1) begin errors++; $display("FAIL first_tick_hcount: got %0d expected 1", vif_d.hcount); end
    @(negedge clk100);
    checks++; if (vif_d.pix_tick !== 1'b0) begin errors++; $display("FAIL first_tick_width: got %b expected 0", vif_d.pix_tick); end
    checks++; if (vif_d.hcount !== 9'd1) begin errors++; $display("FAIL first_tick_hold: got %0d expected 1", vif_d.hcount); end
    sc1h = 1'b0; repeat (2) @(negedge clk100);
  endtask

  task automatic test_line_wrap();
    repeat (454) pix(8);
    checks++; if (vif_d.hcount !== 9'd455) begin errors++; $display("FAIL pre_wrap_hcount: got %0d expected 455", vif_d.hcount); end
    checks++; if (vif_d.vcount !== 9'd0) begin errors++; $display("FAIL pre_wrap_vcount: got %0d expected 0", vif_d.vcount); end
    checks++; if (vif_d.HBLANK !== 1'b1) begin errors++; $display("FAIL pre_wrap_hblank: got %b expected 1", vif_d.HBLANK); end
    sc1h = 1'b1; @(negedge clk100);
    checks++; if (vif_d.hcount !== 9'd0) begin errors++; $display("FAIL wrap_hcount: got %0d expected 0", vif_d.hcount); end
    checks++; if (vif_d.vcount !== 9'd1) begin errors++; $display("FAIL wrap_vcount: got %0d expected 1", vif_d.vcount); end
    checks++; if (vif_d.line_start !== 1'b1) begin errors++; $display("FAIL wrap_line_start: got %b expected 1", vif_d.line_start); end
    checks++; if (vif_d.frame_start !== 1'b0) begin errors++; $display("FAIL wrap_frame_start: got %b expected 0", vif_d.frame_start); end
    checks++; if (vif_d.HBLANK !== 1'b0) begin errors++; $display("FAIL wrap_hblank: got %b expected 0", vif_d.HBLANK); end
    @(negedge clk100);
    checks++; if (vif_d.line_start !== 1'b0) begin errors++; $display("FAIL line_start_width: got %b expected 0", vif_d.line_start); end
    sc1h = 1'b0; repeat (2) @(negedge clk100);
  endtask

  task automatic test_hblank_hsync();
    int h;
    logic exp_hb, exp_hs;
    for (int i = 1; i <= 456; i++) begin
      h = i % 456;
      exp_hb = (h >= 320);
      exp_hs = (h >= 336) && (h <= 367);
      sc1h = 1'b1; @(negedge clk100);
      checks++; if (vif_d.hcount !== 9'(h)) begin errors++; $display("FAIL line_hcount: got %0d expected %0d", vif_d.hcount, h); end
      checks++; if (vif_d.HBLANK !== exp_hb) begin errors++; $display("FAIL hblank h=%0d: got %b expected %b", h, vif_d.HBLANK, exp_hb); end
      checks++; if (vif_d.HSYNC !== exp_hs) begin errors++; $display("FAIL hsync h=%0d: got %b expected %b", h, vif_d.HSYNC, exp_hs); end
      checks++; if (vif_d.line_start !== (h == 0)) begin errors++; $display("FAIL line_start h=%0d: got %b expected %b", h, vif_d.line_start, (h == 0)); end
`ifdef VSG_CSYNC_EN
      checks++; if (vif_d.CSYNC !== exp_hs) begin errors++; $display("FAIL csync_line h=%0d: got %b expected %b", h, vif_d.CSYNC, exp_hs); end
`endif
      sc1h = 1'b0; @(negedge clk100);
    end
    checks++; if (vif_d.vcount !== 9'd2) begin errors++; $display("FAIL line_end_vcount: got %0d expected 2", vif_d.vcount); end
    checks++; if (vif_d.VBLANK !== 1'b0) begin errors++; $display("FAIL line_end_vblank: got %b expected 0", vif_d.VBLANK); end
  endtask

  task automatic test_mid_reset();
    repeat (48 * 456 + 100) pix(2);
    checks++; if (vif_d.hcount !== 9'd100) begin errors++; $display("FAIL pre_reset_hcount: got %0d expected 100", vif_d.hcount); end
    checks++; if (vif_d.vcount !== 9'd50) begin errors++; $display("FAIL pre_reset_vcount: got %0d expected 50", vif_d.vcount); end
    @(posedge clk100);
    #2 rst = 1'b1;
    #1;
    checks++; if (outs_d() !== 20'd0) begin errors++; $display("FAIL async_reset_outputs: got %h expected 0", outs_d()); end
    @(negedge clk100);
    rst = 1'b0; sc1h = 1'b0;
    repeat (3) @(negedge clk100);
    checks++; if (vif_d.hcount !== 9'd0) begin errors++; $display("FAIL post_reset_hcount: got %0d expected 0", vif_d.hcount); end
    sc1h = 1'b1; @(negedge clk100);
    checks++; if (vif_d.hcount !== 9'd1) begin errors++; $display("FAIL post_reset_first: got %0d expected 1", vif_d.hcount); end
    checks++; if (vif_d.pix_tick !== 1'b1) begin errors++; $display("FAIL post_reset_tick: got %b expected 1", vif_d.pix_tick); end
    sc1h = 1'b0; @(negedge clk100);
  endtask

  task automatic test_small_frame();
    int h, v, frames;
    logic exp_vb, exp_vs, exp_hb, exp_hs;
    rst = 1'b1; sc1h = 1'b0;
    @(negedge clk100);
    rst = 1'b0;
    repeat (2) @(negedge clk100);
    checks++; if ({vif_s.hcount, vif_s.vcount} !== 18'd0) begin errors++; $display("FAIL small_reset: got %0d/%0d expected 0/0", vif_s.hcount, vif_s.vcount); end
    h = 0; v = 0; frames = 0;
    for (int i = 1; i <= 80; i++) begin
      if (h == 7) begin h = 0; v = (v == 9) ? 0 : v + 1; end
      else h = h + 1;
      exp_hb = (h >= 5);
      exp_hs = (h >= 5) && (h <= 6);
      exp_vb = (v >= 6);
      exp_vs = (v >= 7) && (v <= 9);
      sc1h = 1'b1; @(negedge clk100);
      checks++; if ({vif_s.hcount, vif_s.vcount} !== {9'(h), 9'(v)}) begin errors++; $display("FAIL small_pos: got %0d/%0d expected %0d/%0d", vif_s.hcount, vif_s.vcount, h, v); end
      checks++; if ({vif_s.HBLANK, vif_s.HSYNC} !== {exp_hb, exp_hs}) begin errors++; $display("FAIL small_hflags h=%0d: got %b%b expected %b%b", h, vif_s.HBLANK, vif_s.HSYNC, exp_hb, exp_hs); end
      checks++; if ({vif_s.VBLANK, vif_s.VSYNC} !== {exp_vb, exp_vs}) begin errors++; $display("FAIL small_vflags v=%0d: got %b%b expected %b%b", v, vif_s.VBLANK, vif_s.VSYNC, exp_vb, exp_vs); end
      checks++; if ({vif_s.line_start, vif_s.frame_start} !== {(h == 0), (h == 0 && v == 0)}) begin errors++; $display("FAIL small_strobes %0d/%0d: got %b%b", h, v, vif_s.line_start, vif_s.frame_start); end
`ifdef VSG_CSYNC_EN
      checks++; if (vif_s.CSYNC !== (exp_hs ^ exp_vs)) begin errors++; $display("FAIL small_csync %0d/%0d: got %b expected %b", h, v, vif_s.CSYNC, exp_hs ^ exp_vs); end
`endif
      if (vif_s.frame_start === 1'b1) frames++;
      sc1h = 1'b0; @(negedge clk100);
      checks++; if ({vif_s.line_start, vif_s.frame_start} !== 2'b00) begin errors++; $display("FAIL small_strobe_width: got %b%b expected 00", vif_s.line_start, vif_s.frame_start); end
    end
    checks++; if (frames != 1) begin errors++; $display("FAIL frame_start_count: got %0d expected 1", frames); end
    checks++; if ({vif_s.hcount, vif_s.vcount} !== 18'd0) begin errors++; $display("FAIL frame_end_pos: got %0d/%0d expected 0/0", vif_s.hcount, vif_s.vcount); end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_line_wrap();
    test_hblank_hsync();
    test_mid_reset();
    test_small_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
